alu_cmd_issuer: RTL

- Initiator for the team's 8-bit combinational ALU.
- Accepts operation commands over a valid/ready channel and drives the ALU operand/opcode inputs.
- Waits a programmable settle time, then captures the ALU result and flags, masking stale ones.
- Returns them on a valid/ready response channel; keeps an accumulator so operations can be chained.

---
 rtl/alu_cmd_issuer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command initiator for the 8-bit combinational ALU.
// Accepts a command, drives the ALU inputs, waits SETTLE_CYCLES (legal 1..15),
// captures the result and flags with stale outputs masked per opcode, and
// returns them on a valid/ready response channel. Captured results of the
// arithmetic/logic opcodes are kept in an accumulator for chaining.
module alu_cmd_issuer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  // command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  // ALU drive
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_opcode,
  // ALU return
  input  logic [7:0] alu_c,
  input  logic       alu_carry,
  input  logic       alu_borrow,
  input  logic       alu_equal,
  input  logic       alu_less,
  input  logic       alu_more,
  // response channel
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [4:0] rsp_flags,
  // status
  output logic [7:0] acc,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [3:0] SETTLE = SETTLE_CYCLES[3:0];

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       cmd_ready_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_result_q;
  logic [4:0] rsp_flags_q;
  logic [7:0] acc_q;
  logic       busy_q;

  logic [7:0] cap_result_d;
  logic [4:0] cap_flags_d;
  logic       cap_acc_we;

  // Mask stale ALU outputs according to the opcode currently being driven.
  always_comb begin
    cap_result_d = alu_c;
    cap_flags_d  = '0;
    cap_acc_we   = 1'b1;
    unique case (alu_op_q)
      OP_ADD: cap_flags_d = {alu_carry, 4'b0000};
      OP_SUB: cap_flags_d = {1'b0, alu_borrow, 3'b000};
      OP_CMP: begin
        cap_result_d = '0;
        cap_flags_d  = {2'b00, alu_equal, alu_less, alu_more};
        cap_acc_we   = 1'b0;
      end
      OP_CLR: begin
        cap_result_d = '0;
        cap_acc_we   = 1'b0;
      end
      default: ;
    endcase
  end

  // Command/settle/response FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_CLR;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a_q     <= cmd_use_acc ? acc_q : cmd_a;
            alu_b_q     <= cmd_b;
            alu_op_q    <= cmd_opcode;
            cnt_q       <= SETTLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // <= 1 also covers an out-of-range zero setting as a one-cycle settle
          if (cnt_q <= 4'd1) begin
            rsp_result_q <= cap_result_d;
            rsp_flags_q  <= cap_flags_d;
            if (cap_acc_we) begin
              acc_q <= cap_result_d;
            end
            rsp_valid_q  <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign acc        = acc_q;
  assign busy       = busy_q;

endmodule
